// File: rtl/fir_sequencer_if.sv
// fir_sequencer_if
//   Handshake and bus bundle for the time-multiplexed FIR sequencer.
//   master : sample/coefficient producer plus consumer of the filter result
//   slave  : the fir_sequencer itself
// Signals:
//   sample_valid / voltage[9:0]       one-cycle sample strobe and unsigned ADC value
//   coef_we / coef_addr[3:0] / coef_data[CW-1:0]   coefficient write port
//   busy                              sequencer is computing or presenting a result
//   filtered_valid / filtered[9:0]    one-cycle result strobe and held result
//   overrun                           sticky flag: a sample arrived while busy
interface fir_sequencer_if #(
  parameter int CW = 16
);
  logic          sample_valid;
  logic [9:0]    voltage;
  logic          coef_we;
  logic [3:0]    coef_addr;
  logic [CW-1:0] coef_data;
  logic          busy;
  logic          filtered_valid;
  logic [9:0]    filtered;
  logic          overrun;

  modport master (
    output sample_valid, voltage, coef_we, coef_addr, coef_data,
    input  busy, filtered_valid, filtered, overrun
  );

  modport slave (
    input  sample_valid, voltage, coef_we, coef_addr, coef_data,
    output busy, filtered_valid, filtered, overrun
  );
endinterface

// File: rtl/fir_sequencer.sv
// fir_sequencer
//   Time-multiplexed symmetric FIR (TAPS taps, (TAPS+1)/2 folded pairs).
//   Accepted samples go into a circular buffer; one pre-add/multiply/accumulate
//   unit then walks the folded coefficient pairs, one per clock, and the rounded,
//   saturated result is presented on filtered with a one-cycle filtered_valid.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : fir_sequencer_if.slave (sample input, coefficient writes, result, status)
// The reset coefficient table holds the 16 low-pass values for TAPS = 31.
module fir_sequencer #(
  parameter int TAPS = 31,
  parameter int CW   = 16
) (
  input logic             clk,
  input logic             reset,
  fir_sequencer_if.slave  bus
);
  localparam int PAIRS = (TAPS + 1) / 2;
  localparam int KW    = $clog2(PAIRS);
  localparam int PW    = $clog2(TAPS);
  localparam int XW    = 10;
  localparam int SW    = XW + 1;      // pre-add width
  localparam int PRODW = CW + SW;     // product width
  localparam int ACCW  = 32;

  localparam logic [PW:0]     TAPS_X  = (PW+1)'(TAPS);
  localparam logic [PW:0]     ONE_X   = (PW+1)'(1);
  localparam logic [PW-1:0]   WP_LAST = PW'(TAPS - 1);
  localparam logic [KW-1:0]   K_LAST  = KW'(PAIRS - 1);
  localparam logic [ACCW-1:0] ROUND   = ACCW'(1) << (CW - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  function automatic logic [CW-1:0] coef_default(input int i);
    case (i)
      0:  return CW'(210);
      1:  return CW'(256);
      2:  return CW'(360);
      3:  return CW'(531);
      4:  return CW'(780);
      5:  return CW'(1088);
      6:  return CW'(1455);
      7:  return CW'(1868);
      8:  return CW'(2300);
      9:  return CW'(2746);
      10: return CW'(3172);
      11: return CW'(3552);
      12: return CW'(3880);
      13: return CW'(4129);
      14: return CW'(4280);
      15: return CW'(4332);
      default: return '0;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [XW-1:0]   sbuf_q [TAPS];
  logic [XW-1:0]   sbuf_d [TAPS];
  logic [CW-1:0]   coef_q [PAIRS];
  logic [CW-1:0]   coef_d [PAIRS];
  logic [PW-1:0]   wp_q, wp_d, wp_next;
  logic [KW-1:0]   k_q, k_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [XW-1:0]   filtered_q, filtered_d;
  logic            filtered_valid_q, filtered_valid_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;

  logic            accept;
  logic [PW:0]     wp_x, k_x, b_sum;
  logic [PW-1:0]   idx_a, idx_b;
  logic [SW-1:0]   pre_add;
  logic [PRODW-1:0] product;

  // busy_q also covers the filtered_valid cycle, so a low busy_q implies IDLE.
  assign accept  = bus.sample_valid && !busy_q;
  assign wp_next = (wp_q == WP_LAST) ? '0 : wp_q + PW'(1);

  // Datapath for term k: newest-side tap (wp - k) mod TAPS and oldest-side tap
  // (wp - (TAPS-1) + k) mod TAPS = (wp + 1 + k) mod TAPS. The centre term has no
  // partner; both indices coincide there, so the second operand is suppressed.
  always_comb begin
    wp_x  = (PW+1)'(wp_q);
    k_x   = (PW+1)'(k_q);
    idx_a = (wp_x >= k_x) ? PW'(wp_x - k_x) : PW'(wp_x + TAPS_X - k_x);
    b_sum = wp_x + k_x + ONE_X;
    idx_b = (b_sum >= TAPS_X) ? PW'(b_sum - TAPS_X) : PW'(b_sum);
    pre_add = {1'b0, sbuf_q[idx_a]};
    if (k_q != K_LAST) pre_add = pre_add + {1'b0, sbuf_q[idx_b]};
    product = PRODW'(coef_q[k_q]) * PRODW'(pre_add);
  end

  // NOTE: every _d starts from its _q (or a safe default) so no path through
  // this block leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d          = state_q;
    sbuf_d           = sbuf_q;
    coef_d           = coef_q;
    wp_d             = wp_q;
    k_d              = k_q;
    acc_d            = acc_q;
    filtered_d       = filtered_q;
    filtered_valid_d = 1'b0;
    overrun_d        = overrun_q;

    if (bus.sample_valid && busy_q) overrun_d = 1'b1;
    // Coefficient writes land before the MAC starts, so a write in the accept
    // cycle is already visible to the first term.
    if (bus.coef_we && !busy_q) coef_d[bus.coef_addr] = bus.coef_data;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sbuf_d[wp_next] = bus.voltage;
          wp_d            = wp_next;
          k_d             = '0;
          acc_d           = ROUND;
          state_d         = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACCW'(product);
        if (k_q == K_LAST) state_d = DONE;
        else               k_d     = k_q + KW'(1);
      end
      DONE: begin
        filtered_d       = (|acc_q[ACCW-1:CW+XW]) ? '1 : acc_q[CW+XW-1:CW];
        filtered_valid_d = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      wp_q             <= '0;
      k_q              <= '0;
      acc_q            <= '0;
      filtered_q       <= '0;
      filtered_valid_q <= 1'b0;
      overrun_q        <= 1'b0;
      busy_q           <= 1'b0;
      // NOTE: the sample buffer is deliberately reset; the first outputs after
      // reset convolve against zeros, not stale history.
      for (int i = 0; i < TAPS; i++)  sbuf_q[i] <= '0;
      for (int i = 0; i < PAIRS; i++) coef_q[i] <= coef_default(i);
    end else begin
      state_q          <= state_d;
      sbuf_q           <= sbuf_d;
      coef_q           <= coef_d;
      wp_q             <= wp_d;
      k_q              <= k_d;
      acc_q            <= acc_d;
      filtered_q       <= filtered_d;
      filtered_valid_q <= filtered_valid_d;
      overrun_q        <= overrun_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.filtered_valid = filtered_valid_q;
  assign bus.filtered       = filtered_q;
  assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer
//   Directed and randomized stimulus for fir_sequencer. Expected results come
//   from a direct 31-tap convolution over the full history of accepted samples.
module tb_fir_sequencer;
  logic clk = 1'b0;
  logic reset;

  fir_sequencer_if #(.CW(16)) bus ();

  fir_sequencer #(.TAPS(31), .CW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hist[$];
  int coef_m[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_coefs();
    coef_m = '{210, 256, 360, 531, 780, 1088, 1455, 1868,
               2300, 2746, 3172, 3552, 3880, 4129, 4280, 4332};
  endtask

  // Direct convolution: y = sum_j h[j]*x[n-j] with h symmetric, plus rounding.
  function automatic int model_out();
    longint acc;
    int x;
    int c;
    acc = 32768;
    for (int j = 0; j < 31; j++) begin
      x = (j < hist.size()) ? hist[hist.size() - 1 - j] : 0;
      c = coef_m[(j <= 15) ? j : 30 - j];
      acc += longint'(c) * longint'(x);
    end
    acc = acc / 65536;
    return (acc > 1023) ? 1023 : int'(acc);
  endfunction

  task automatic do_reset();
    bus.sample_valid = 1'b0;
    bus.coef_we      = 1'b0;
    reset            = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    hist.delete();
    set_default_coefs();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic write_coef(input int addr, input int data);
    wait_idle();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = 16'(data);
    tick();
    bus.coef_we = 1'b0;
    coef_m[addr] = data;
  endtask

  // Feed one sample (optionally with a same-cycle coefficient write), then
  // check latency, result, strobe width and busy release.
  task automatic run_sample(input int v, input bit with_coef, input int addr, input int data);
    int n;
    wait_idle();
    bus.sample_valid = 1'b1;
    bus.voltage      = 10'(v);
    if (with_coef) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'(addr);
      bus.coef_data = 16'(data);
      coef_m[addr]  = data;
    end
    tick();
    bus.sample_valid = 1'b0;
    bus.coef_we      = 1'b0;
    hist.push_back(v);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.filtered_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd17);
    check("filtered", 32'(bus.filtered), 32'(model_out()));
    check("busy_in_valid_cycle", 32'(bus.busy), 32'd1);
    tick();
    check("valid_one_cycle", 32'(bus.filtered_valid), 32'd0);
    check("busy_release", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    bit seen;
    logic [9:0] held;

    bus.sample_valid = 1'b0;
    bus.voltage      = '0;
    bus.coef_we      = 1'b0;
    bus.coef_addr    = '0;
    bus.coef_data    = '0;

    // Reset state
    do_reset();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_filtered", 32'(bus.filtered), 32'd0);
    check("reset_valid", 32'(bus.filtered_valid), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);

    // Impulse response, samples 20 clocks apart
    for (int i = 0; i < 31; i++) begin
      run_sample((i == 0) ? 1000 : 0, 1'b0, 0, 0);
      if (i == 0)  check("impulse_first", 32'(bus.filtered), 32'd3);
      if (i == 15) check("impulse_centre", 32'(bus.filtered), 32'd66);
      if (i == 30) check("impulse_last", 32'(bus.filtered), 32'd3);
      repeat (1) tick();
    end
    // filtered holds between updates
    held = bus.filtered;
    repeat (5) tick();
    check("filtered_hold", 32'(bus.filtered), 32'(held));

    // DC gain
    do_reset();
    for (int i = 0; i < 40; i++) run_sample(1000, 1'b0, 0, 0);
    check("dc_1000", 32'(bus.filtered), 32'd1000);
    for (int i = 0; i < 31; i++) run_sample(1023, 1'b0, 0, 0);
    check("dc_1023", 32'(bus.filtered), 32'd1023);

    // Saturation with full-scale coefficients
    do_reset();
    for (int a = 0; a < 16; a++) write_coef(a, 65535);
    for (int i = 0; i < 31; i++) run_sample(1023, 1'b0, 0, 0);
    check("sat_value", 32'(bus.filtered), 32'd1023);
    check("sat_no_overrun", 32'(bus.overrun), 32'd0);

    // Overrun: second sample at E5 is dropped
    do_reset();
    run_sample(321, 1'b0, 0, 0);
    bus.sample_valid = 1'b1;
    bus.voltage      = 10'd500;
    tick();                                   // E0
    bus.sample_valid = 1'b0;
    hist.push_back(500);
    repeat (4) tick();                        // after E4
    bus.sample_valid = 1'b1;
    bus.voltage      = 10'd777;
    tick();                                   // E5
    bus.sample_valid = 1'b0;
    check("overrun_set", 32'(bus.overrun), 32'd1);
    n = 5;
    while (!bus.filtered_valid && n < 40) begin
      tick();
      n++;
    end
    check("overrun_latency", 32'(n), 32'd17);
    check("overrun_result", 32'(bus.filtered), 32'(model_out()));
    tick();
    run_sample(123, 1'b0, 0, 0);
    check("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Pointer wrap with a distinct ramp
    do_reset();
    base = int'($urandom_range(0, 1023));
    for (int i = 0; i < 62; i++) run_sample((base + 7 * i) % 1024, 1'b0, 0, 0);

    // Random coefficients and samples, including same-cycle coef+sample
    do_reset();
    for (int i = 0; i < 4; i++) write_coef(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
    for (int i = 0; i < 40; i++) begin
      if ((i % 5) == 2)
        run_sample(int'($urandom_range(0, 1023)), 1'b1,
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
      else
        run_sample(int'($urandom_range(0, 1023)), 1'b0, 0, 0);
    end

    // Reset mid-MAC with coefficient write lockout
    do_reset();
    bus.sample_valid = 1'b1;
    bus.voltage      = 10'd900;
    tick();                                   // E0
    bus.sample_valid = 1'b0;
    repeat (7) tick();                        // after E7
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'd0;
    bus.coef_data = 16'd0;
    tick();                                   // E8
    bus.coef_we = 1'b0;
    check("busy_mid_mac", 32'(bus.busy), 32'd1);
    tick();                                   // after E9
    reset = 1'b1;
    tick();                                   // E10
    reset = 1'b0;
    hist.delete();
    set_default_coefs();
    check("busy_after_midreset", 32'(bus.busy), 32'd0);
    check("filtered_after_midreset", 32'(bus.filtered), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.filtered_valid) seen = 1'b1;
      tick();
    end
    check("no_valid_after_midreset", 32'(seen), 32'd0);
    run_sample(1000, 1'b0, 0, 0);
    check("c0_restored", 32'(bus.filtered), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
